// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32 core.
// Keeps one instruction-memory request in flight and supports stall, redirect and flush.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic [6:0]      instr_opcode
);

  typedef enum logic [1:0] {FETCH, WAIT, HOLD} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic            kill, kill_next;
  logic [31:0]     hold_buf, hold_buf_next;
  logic            load;
  logic [31:0]     load_instr;
  logic [XLEN-1:0] redirect_pc;

  // Masking (rather than slicing) keeps every bit of branch_target in use.
  assign redirect_pc = branch_target & ~XLEN'(3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      kill        <= 1'b0;
      hold_buf    <= NOP_INSTR;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      kill     <= kill_next;
      hold_buf <= hold_buf_next;
      if (branch_taken) begin
        if_id_valid <= 1'b0;
        if_id_pc    <= '0;
        if_id_instr <= NOP_INSTR;
      end else if (load) begin
        if_id_valid <= 1'b1;
        if_id_pc    <= pc;
        if_id_instr <= load_instr;
      end else if (!stall) begin
        if_id_valid <= 1'b0;
        if_id_instr <= NOP_INSTR;
      end
    end
  end

  always_comb begin
    state_next    = state;
    kill_next     = kill;
    hold_buf_next = hold_buf;
    load          = 1'b0;
    load_instr    = hold_buf;
    case (state)
      FETCH: begin
        // A grant in the redirect cycle was for the old PC, so its response is marked dead.
        if (imem_gnt) begin
          state_next = WAIT;
          kill_next  = branch_taken;
        end
      end
      WAIT: begin
        if (branch_taken) begin
          if (imem_rvalid) begin
            state_next = FETCH;
            kill_next  = 1'b0;
          end else begin
            kill_next  = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (kill) begin
            state_next = FETCH;
            kill_next  = 1'b0;
          end else if (!stall) begin
            state_next = FETCH;
            load       = 1'b1;
            load_instr = imem_rdata;
          end else begin
            state_next    = HOLD;
            hold_buf_next = imem_rdata;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_next = FETCH;
        end else if (!stall) begin
          state_next = FETCH;
          load       = 1'b1;
        end
      end
      default: state_next = FETCH;
    endcase
    pc_next = pc;
    if (branch_taken) begin
      pc_next = redirect_pc;
    end else if (load) begin
      pc_next = pc + XLEN'(4);
    end
  end

  always_comb begin
    imem_req     = (state == FETCH) && !rst;
    imem_addr    = pc;
    instr_opcode = if_id_instr[6:0];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, then randomized traffic
// against a flag-and-buffer reference model and a latency-randomized memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_gnt, imem_rvalid;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_instr;
  logic [6:0]  instr_opcode;

  int n_checks = 0;
  int n_pass   = 0;

  // Memory stand-in: one outstanding access with a programmable response delay
  bit          mem_busy = 0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = '0;
  int          lat_fixed = 1;

  // Reference model: what has been fetched, what is parked, what IF/ID holds
  logic [31:0] m_pc = '0;
  bit          m_pending = 0, m_kill = 0, m_held = 0;
  logic [31:0] m_buf = '0;
  bit          m_valid = 0;
  logic [31:0] m_ifpc = '0, m_instr = NOP;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .instr_opcode(instr_opcode)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:  return 32'h00A00093;
      32'h4:  return 32'h00208133;
      32'h8:  return 32'h0000A183;
      32'h10: return 32'h00412023;
      default: return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  task automatic checkOutput();
    bit exp_req;
    exp_req = !rst && !m_pending && !m_held;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("if_id_valid", 32'(if_id_valid), 32'(m_valid));
    check("if_id_pc", if_id_pc, m_ifpc);
    check("if_id_instr", if_id_instr, m_instr);
    check("instr_opcode", 32'(instr_opcode), 32'(m_instr[6:0]));
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit b,
                               input logic [31:0] t, input bit g);
    bit          granted;
    bit          do_load;
    logic [31:0] gaddr, nxt;
    rst = r; stall = s; branch_taken = b; branch_target = t; imem_gnt = g;
    imem_rvalid = mem_busy && (mem_cnt == 1);
    imem_rdata  = imem_rvalid ? memf(mem_addr) : $urandom;
    #2;
    granted = imem_req && g;
    gaddr   = imem_addr;
    do_load = 0;
    nxt     = '0;
    if (r) begin
      m_pc = '0; m_pending = 0; m_kill = 0; m_held = 0;
      m_valid = 0; m_ifpc = '0; m_instr = NOP;
    end else if (b) begin
      if (m_held) m_held = 0;
      else if (m_pending) begin
        if (imem_rvalid) begin m_pending = 0; m_kill = 0; end
        else m_kill = 1;
      end else if (g) begin m_pending = 1; m_kill = 1; end
      m_pc = {t[31:2], 2'b00};
      m_valid = 0; m_ifpc = '0; m_instr = NOP;
    end else begin
      if (m_pending) begin
        if (imem_rvalid) begin
          m_pending = 0;
          if (m_kill) m_kill = 0;
          else if (!s) begin do_load = 1; nxt = imem_rdata; end
          else begin m_held = 1; m_buf = imem_rdata; end
        end
      end else if (m_held) begin
        if (!s) begin do_load = 1; nxt = m_buf; m_held = 0; end
      end else if (g) m_pending = 1;
      if (do_load) begin
        m_valid = 1; m_ifpc = m_pc; m_instr = nxt; m_pc = m_pc + 32'd4;
      end else if (!s) begin
        m_valid = 0; m_instr = NOP;
      end
    end
    @(posedge clk);
    if (r || imem_rvalid) mem_busy = 0;
    else if (mem_busy) mem_cnt--;
    if (!r && granted) begin
      mem_busy = 1;
      mem_addr = gaddr;
      mem_cnt  = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 3);
    end
    #1;
    checkOutput();
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    check("rst_req", 32'(imem_req), 0);
    check("rst_opcode", 32'(instr_opcode), 32'h13);
    check("rst_pc", if_id_pc, 0);

    // Zero-wait memory fetching addresses 0, 4, 8
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      if (i == 1) begin
        check("seq_pc0", if_id_pc, 32'h0);
        check("seq_op0", 32'(instr_opcode), 32'b0010011);
      end
      if (i == 2) check("seq_bubble", 32'(if_id_valid), 0);
      if (i == 3) check("seq_op1", 32'(instr_opcode), 32'b0110011);
      if (i == 5) begin
        check("seq_pc8", if_id_pc, 32'h8);
        check("seq_op2", 32'(instr_opcode), 32'b0000011);
        check("model_instr2", m_instr, 32'h0000A183);
      end
    end

    // Stall across the response for PC 0x10
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    check("hold_keeps_pc", if_id_pc, 32'hC);
    check("hold_no_req", 32'(imem_req), 0);
    applyStimulus(0, 0, 0, 0, 0);
    check("unhold_pc", if_id_pc, 32'h10);
    check("unhold_instr", if_id_instr, 32'h00412023);
    check("unhold_next_addr", imem_addr, 32'h14);

    // Redirect to 0x43 in the same cycle as the grant for 0x20
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);
    check("pre_branch_addr", imem_addr, 32'h20);
    applyStimulus(0, 0, 1, 32'h43, 1);
    check("flush_valid", 32'(if_id_valid), 0);
    check("flush_instr", if_id_instr, NOP);
    applyStimulus(0, 0, 0, 0, 0);
    check("redirect_req", 32'(imem_req), 1);
    check("redirect_addr", imem_addr, 32'h40);

    // Redirect with stall while holding a buffered word
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 32'h100, 0);
    check("hold_flush_valid", 32'(if_id_valid), 0);
    check("hold_flush_addr", imem_addr, 32'h100);
    check("hold_flush_req", 32'(imem_req), 1);

    // No grant for 5 cycles
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
    check("nogrant_addr", imem_addr, 32'h100);

    // PC wrap at the top of the address space
    applyStimulus(0, 0, 1, 32'hFFFF_FFFE, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0);
    check("wrap_ifpc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset while a response is outstanding
    lat_fixed = 2;
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0);
    check("midrst_req", 32'(imem_req), 0);
    check("midrst_valid", 32'(if_id_valid), 0);
    check("midrst_instr", if_id_instr, NOP);

    // Randomized traffic
    lat_fixed = 0;
    for (int i = 0; i < 3000; i++) begin
      bit          r, s, b, g;
      logic [31:0] t;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 11) == 0);
      g = ($urandom_range(0, 1) == 1);
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
      applyStimulus(r, s, b, t, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage plus IF/ID pipeline register for the multi-stage RV32 core. It drives the instruction memory through a request/grant/response handshake and holds one fetched instruction with its PC. It supplies `instr_opcode` to the ID-stage control unit. It supports stall from the hazard logic and redirect/flush on taken branches, and inserts a NOP bubble whenever no valid instruction is available.

## Interface
- `XLEN`, 32, PC and address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (addi x0,x0,0); the control unit decodes it to all-zero controls

- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hazard unit: hold IF/ID contents and do not advance PC
- `branch_taken`  in  1  single-cycle redirect request from EX
- `branch_target`  in  XLEN  redirect address; bits [1:0] are ignored and forced to 0
- `imem_req`  out  1  fetch request
- `imem_addr`  out  XLEN  fetch address; equals `pc` while `imem_req` = 1
- `imem_gnt`  in  1  request accepted this cycle when `imem_req` & `imem_gnt`
- `imem_rvalid`  in  1  response valid, ≥1 cycle after grant, one per grant
- `imem_rdata`  in  32  instruction word
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `if_id_pc`  out  XLEN  PC of the IF/ID instruction
- `if_id_instr`  out  32  IF/ID instruction (`NOP_INSTR` when not valid)
- `instr_opcode`  out  7  `if_id_instr[6:0]`, combinational from the register

## Operation
- The state machine has three states: FETCH, WAIT and HOLD. Only one request is ever outstanding.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - On grant, go to WAIT.
  - Without a grant, stay in FETCH; the address may change only on a redirect.
- WAIT:
  - `imem_req` = 0.
  - On `imem_rvalid` with `kill` = 1: drop the response, clear `kill`, go to FETCH.
  - On `imem_rvalid` with `stall` = 0: load IF/ID with {1, `pc`, `imem_rdata`}, set `pc` ← `pc`+4, go to FETCH.
  - On `imem_rvalid` with `stall` = 1: capture `imem_rdata` into the hold buffer and go to HOLD. IF/ID is unchanged.
- HOLD:
  - When `stall` = 0: load IF/ID from the buffer, set `pc` ← `pc`+4, go to FETCH.
- Redirect (`branch_taken` = 1) has the highest priority and overrides `stall`:
  - IF/ID is flushed: `if_id_valid` ← 0, `if_id_instr` ← `NOP_INSTR`, `if_id_pc` ← 0.
  - `pc` ← {`branch_target`[XLEN-1:2], 2'b00}.
  - FETCH without grant: stay in FETCH; the new address appears next cycle.
  - FETCH with grant in the same cycle: go to WAIT with `kill` = 1, because the old-PC response must be dropped.
  - WAIT: set `kill` = 1. If `imem_rvalid` arrives in the same cycle, drop that response and go directly to FETCH.
  - HOLD: discard the buffer and go to FETCH.
- Downstream consumption: if `stall` = 0 and no new instruction is loaded this cycle, IF/ID becomes a bubble (`if_id_valid` ← 0, `if_id_instr` ← `NOP_INSTR`), because ID consumed the previous entry. If `stall` = 1, IF/ID holds its current value, whether valid or bubble.
- The PC wraps modulo 2^XLEN; 0xFFFF_FFFC + 4 gives 0.

## Timing
- Reset values (while `rst` = 1 at posedge):
  - state = FETCH, `pc` = `RESET_PC`, `kill` = 0.
  - `imem_req` = 0 during reset and 1 from the first cycle after `rst` deasserts.
  - `if_id_valid` = 0, `if_id_pc` = 0, `if_id_instr` = `NOP_INSTR`, so `instr_opcode` = 7'b0010011.
- Reset mid-operation abandons any outstanding response. The memory side must also be reset by the same `rst`.
- Best-case latency: grant in cycle N, `rvalid` in cycle N+1, IF/ID visible in cycle N+2.
- Throughput is one instruction per 2 cycles, limited by one outstanding request.
- Redirect takes effect at the posedge where `branch_taken` = 1. The request to the target is issued the next cycle, except when a response is still pending.

## Test plan
- Reset, then zero-wait memory (grant same cycle, `rvalid` next cycle) returning 0x00A00093, 0x00208133, 0x0000A183 at addresses 0, 4, 8 -> IF/ID shows pc 0/4/8 valid; `instr_opcode` is 0010011, 0110011, 0000011 in turn; bubbles appear between them.
- `stall` = 1 for 3 cycles while `rvalid` returns 0x00412023 at PC 0x10 -> state enters HOLD; IF/ID keeps its old entry; the cycle after `stall` drops, IF/ID = {1, 0x10, 0x00412023} and the next request goes to 0x14.
- `branch_taken` with target 0x43 in the same cycle as a grant for PC 0x20 -> the response for 0x20 is dropped; the next request goes to 0x40; IF/ID is flushed to NOP/invalid.
- `branch_taken` together with `stall` = 1 while in HOLD -> the buffer is discarded, IF/ID is flushed, and FETCH issues address = target.
- `imem_gnt` held low for 5 cycles -> `imem_req` stays 1 with a stable `imem_addr`; no IF/ID update occurs.
- PC at 0xFFFF_FFFC fetched -> the next `imem_addr` is 0x0000_0000; `rst` asserted during WAIT -> all outputs return to their reset values the next cycle.
